// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   XLEN          : address/PC width
//   FETCH_NOP     : instruction handed to decode when the PC is misaligned
//   fetch_state_e : RUN (normal fetching) / TRAP (misaligned PC reported)
//   fetch_entry_t : one prefetch buffer entry {instr, pc}
package instr_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] FETCH_NOP = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic isMisaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Prefetch buffer: synchronous FIFO of fetch_entry_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write pushData_i (ignored when full unless popping)
//   pop_i         : drop the head entry (ignored when empty)
//   flush_i       : empty the FIFO; takes priority over push/pop
//   head_o        : current head entry (valid when !empty_o)
//   count_o       : number of stored entries
//   empty_o/full_o: occupancy flags
module fetch_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  fetch_entry_t           pushData_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rdPtr_q;
  logic [AW-1:0] wrPtr_q;
  logic [CW-1:0] count_q;
  logic          doPush;
  logic          doPop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == FULL_COUNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];

  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign doPop  = pop_i && !empty_o;
  assign doPush = push_i && (!full_o || doPop);

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once count covers them.
  always_ff @(posedge clk_i) begin
    if (doPush && !flush_i) mem_q[wrPtr_q] <= pushData_i;
  end

  overflowCheck: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o && !pop_i && !flush_i));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. Owns the PC, issues word-aligned fetch
// requests, buffers in-order responses and presents them to decode.
//   clk, cpu_rstn           : clock, asynchronous active-low reset
//   redirect_valid/_pc      : branch/jump/trap redirect pulse and target
//   imem_req_valid/_ready   : request handshake, imem_req_addr = PC fetched
//   imem_rsp_valid/_data    : in-order response, no backpressure
//   fetch_valid/_ready      : decode handshake on the head instruction
//   fetch_instr             : head instruction (NOP for a misaligned PC)
//   current_pc              : head PC when buffered, else the fetch PC
//   fetch_addr_misaligned   : current_pc is not word aligned
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            cpu_rstn,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [31:0]     fetch_instr,
  output logic [XLEN-1:0] current_pc,
  output logic            fetch_addr_misaligned
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  // Discards can pile up over back-to-back redirects while old responses are
  // still in flight, so this counter gets extra headroom.
  localparam int DW = CW + 2;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rspPc_q, rspPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [DW-1:0]   discard_q, discard_d;

  fetch_entry_t    fifoHead;
  fetch_entry_t    fifoIn;
  logic [CW-1:0]   fifoCount;
  logic            fifoEmpty;
  logic            fifoFull;
  logic            fifoPush;
  logic            fifoPop;
  logic [CW:0]     inFlight;
  logic            reqFire;
  logic            rspKeep;
  logic            misFault;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (cpu_rstn),
    .push_i     (fifoPush),
    .pushData_i (fifoIn),
    .pop_i      (fifoPop),
    .flush_i    (redirect_valid),
    .head_o     (fifoHead),
    .count_o    (fifoCount),
    .empty_o    (fifoEmpty),
    .full_o     (fifoFull)
  );

  // Requests are throttled so every response always has a buffer slot.
  assign inFlight       = {1'b0, outstanding_q} + {1'b0, fifoCount};
  assign imem_req_valid = cpu_rstn && (state_q == RUN) && !isMisaligned(pc_q)
                          && !fifoFull && (inFlight < DEPTH_LIM);
  assign imem_req_addr  = pc_q;
  assign reqFire        = imem_req_valid && imem_req_ready;

  // Responses belonging to requests issued before a redirect are dropped.
  assign rspKeep  = imem_rsp_valid && (discard_q == '0);
  assign fifoPush = rspKeep && !redirect_valid;
  assign fifoIn   = '{instr: imem_rsp_data, pc: rspPc_q};
  assign fifoPop  = fetch_ready && !fifoEmpty;

  // A misaligned PC is only reported once everything older has drained.
  assign misFault = (state_q == RUN) && isMisaligned(pc_q) && fifoEmpty
                    && (outstanding_q == '0);

  assign fetch_valid           = cpu_rstn && (!fifoEmpty || misFault);
  assign fetch_instr           = fifoEmpty ? FETCH_NOP : fifoHead.instr;
  assign current_pc            = fifoEmpty ? pc_q : fifoHead.pc;
  assign fetch_addr_misaligned = isMisaligned(current_pc);

  // Redirect overrides everything: whatever is in flight, including a request
  // accepted this very cycle, becomes a discard, and a response arriving now
  // already consumes one of those.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    rspPc_d       = rspPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (redirect_valid) begin
      state_d       = RUN;
      pc_d          = redirect_pc;
      rspPc_d       = redirect_pc;
      outstanding_d = '0;
      discard_d     = discard_q + DW'(outstanding_q) + DW'(reqFire) - DW'(imem_rsp_valid);
    end else begin
      if (reqFire) pc_d = pc_q + XLEN'(4);
      if (imem_rsp_valid) begin
        if (discard_q != '0) discard_d = discard_q - DW'(1);
        else                 rspPc_d   = rspPc_q + XLEN'(4);
      end
      outstanding_d = outstanding_q + CW'(reqFire) - CW'(rspKeep);
      if (misFault && fetch_ready) state_d = TRAP;
    end
  end

  always_ff @(posedge clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      rspPc_q       <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      rspPc_q       <= rspPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  inFlightBound: assert property (@(posedge clk) disable iff (!cpu_rstn)
    inFlight <= DEPTH_LIM);

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front end of the core. Owns the program counter and issues word-aligned fetch requests to instruction memory with a valid/ready handshake.
- Buffers in-order responses in a small prefetch FIFO and presents instruction, PC and misalignment flag to decode.
- Produces the current_pc and fetch_addr_misaligned signals consumed by the core's decode and formal checks.
- Handles control-flow redirects by flushing the buffer and discarding in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, prefetch entries; power of two, at least 2. Also the maximum in-flight plus buffered requests.

Ports:
- clk  in  1  core clock
- cpu_rstn  in  1  asynchronous active-low reset
- redirect_valid  in  1  branch/jump/trap redirect, single-cycle pulse
- redirect_pc  in  XLEN  redirect target
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address
- imem_rsp_valid  in  1  response valid; in order, no backpressure
- imem_rsp_data  in  32  instruction word
- fetch_valid  out  1  instruction available to decode
- fetch_ready  in  1  decode consumes head
- fetch_instr  out  32  head instruction
- current_pc  out  XLEN  head PC if FIFO non-empty, else pc_q
- fetch_addr_misaligned  out  1  current_pc[1:0] != 0, combinational

Behaviour:
- Clock and reset: one clock, clk. Reset cpu_rstn is asynchronous, active-low.
- Reset values: pc_q=RESET_PC, FIFO empty, outstanding=0, discard=0, state=RUN, imem_req_valid=0, fetch_valid=0.
- States:
  - RUN: normal fetch.
  - TRAP: misaligned PC reported; no requests issued.
- Request issue, in RUN only:
  - imem_req_valid = (pc_q[1:0]==0) && (outstanding + count < FIFO_DEPTH).
  - imem_req_addr = pc_q.
  - On valid&&ready: pc_q += 4 (wraps modulo 2^XLEN) and outstanding++.
  - imem_req_valid and imem_req_addr hold stable until accepted.
- Response handling:
  - If discard != 0: discard--, data dropped.
  - Otherwise: outstanding--, push {data, pc} into the FIFO. PC is tracked by a separate response-PC register, advanced by 4 per accepted response.
  - The FIFO cannot overflow by construction. An overflow is an assertion failure.
- Output:
  - fetch_valid = count != 0.
  - A pop occurs on fetch_valid && fetch_ready.
  - Same-cycle push and pop are allowed; count is unchanged.
- Latency: the earliest fetch_valid is one cycle after imem_rsp_valid, because the FIFO is registered. There is no bypass.
- Misalignment:
  - If RUN, pc_q[1:0] != 0 and the FIFO is empty with outstanding==0:
    - fetch_valid=1, fetch_instr=32'h0000_0013 (NOP), current_pc=pc_q, fetch_addr_misaligned=1.
  - On fetch_ready in that condition: go to TRAP. fetch_valid=0 in TRAP.
  - TRAP is left only by redirect.
- Redirect (highest priority; any state):
  - Next cycle: pc_q=redirect_pc, response-PC=redirect_pc, FIFO flushed, discard = discard + outstanding (minus 1 if a response arrives the same cycle), outstanding=0, state=RUN.
  - A request handshake in the redirect cycle is counted into discard.
  - A pop in the redirect cycle is still a valid consume.
- Reset mid-operation: all state is cleared immediately. The memory is also reset, so no stale responses arrive.
- Invariant: outstanding + count ≤ FIFO_DEPTH. Counter width is $clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package: FETCH_NOP constant (32'h0000_0013), fetch_state_e enum {RUN, TRAP}, and fetch_entry_t struct {instr[31:0], pc[XLEN-1:0]}. XLEN comes from the existing defines.
- Sub-module: fetch_fifo. A synchronous FIFO of fetch_entry_t, depth FIFO_DEPTH, with push/pop/flush, count, empty and full outputs.

Test Plan:
- Reset, then imem_req_ready=1, 1-cycle response latency, fetch_ready=1:
  - Requests go to 0x0, 0x4, 0x8.
  - fetch_pc 0x0 appears with fetch_valid 2 cycles after the first request.
  - Sustained one instruction per cycle.
- Backpressure, fetch_ready=0:
  - Exactly FIFO_DEPTH=2 requests are accepted, then imem_req_valid stays asserted only while outstanding+count<2. No third request.
  - When fetch_ready is released, entries drain in order with the correct PCs.
- Redirect while 2 requests are outstanding, target 0x100:
  - The two late responses are discarded.
  - The next fetch_pc is 0x100 and the next request address is 0x100.
- Redirect to 0x102:
  - No imem request issued.
  - fetch_valid=1, fetch_instr=0x00000013, current_pc=0x102, fetch_addr_misaligned=1.
  - After fetch_ready, state is TRAP.
  - A redirect to 0x200 resumes fetching.
- Wrap-around: RESET_PC=32'hFFFF_FFFC → requests go to 0xFFFFFFFC, then 0x00000000.
- Async reset asserted mid-burst with outstanding=1:
  - All outputs go to reset values without a clock edge.
  - After release, the first request is to RESET_PC.
